// File: rtl/ctrl_decode_seq.sv
// ctrl_decode_seq -- registered, handshaked control decoder with mult/div issue.
//
// Decodes opcode/alu_op into a 14-bit control word and an ALU opcode. Both are
// held in one output register with valid/ready handshakes on each side.
// A mult/div instruction (opcode 0 with alu_op 00110 or 00111) pulses md_start
// and stalls the input side until the multdiv unit reports md_done. The decoded
// word is then delivered with the exception flag reported by the unit.
//
// Optional feature: define CTRL_MD_WATCHDOG_EN to enable a mult/div watchdog.
// After MD_MAX_CYC wait cycles without md_done, the word is delivered with
// md_timeout=1 and rwe cleared. Without the macro the wait is unbounded and
// md_timeout_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_ready_o  instruction handshake
//   opcode_i, alu_op_i       instruction fields
//   out_valid_o/out_ready_i  result handshake
//   ctrl_word_o              {rwe,rdst,aluinb,alusub,dmwe,rwd,br,jp,bne,blt,jal,jr,setx,bex}
//   final_opcode_o           opcode driven to the ALU
//   md_start_o, md_is_div_o  one-cycle issue pulse to multdiv, with div/mul select
//   md_done_i, md_exc_i      multdiv completion pulse and its exception flag
//   out_md_exc_o             exception flag for the delivered mult/div word
//   md_timeout_o             watchdog fired for the delivered word
module ctrl_decode_seq #(
  parameter int OPCODE_W   = 5,
  parameter int ALUOP_W    = 5,
  parameter int MD_MAX_CYC = 40
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [ALUOP_W-1:0]  alu_op_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [13:0]         ctrl_word_o,
  output logic [ALUOP_W-1:0]  final_opcode_o,
  output logic                md_start_o,
  output logic                md_is_div_o,
  input  logic                md_done_i,
  input  logic                md_exc_i,
  output logic                out_md_exc_o,
  output logic                md_timeout_o
);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  // ---------------------------------------------------------------- decode
  // Pad the opcode so the "upper bits are zero" test also works at width 5.
  logic [OPCODE_W+4:0] op_ext;
  logic                op_ok;
  logic [4:0]          op5;

  assign op_ext = {5'b0, opcode_i};
  assign op_ok  = (op_ext[OPCODE_W+4:5] == '0);
  assign op5    = op_ext[4:0];

  logic is_add, is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_setx, is_bex;
  assign is_add  = op_ok && (op5 == 5'b00000);
  assign is_j    = op_ok && (op5 == 5'b00001);
  assign is_bne  = op_ok && (op5 == 5'b00010);
  assign is_jal  = op_ok && (op5 == 5'b00011);
  assign is_jr   = op_ok && (op5 == 5'b00100);
  assign is_addi = op_ok && (op5 == 5'b00101);
  assign is_blt  = op_ok && (op5 == 5'b00110);
  assign is_sw   = op_ok && (op5 == 5'b00111);
  assign is_lw   = op_ok && (op5 == 5'b01000);
  assign is_setx = op_ok && (op5 == 5'b10101);
  assign is_bex  = op_ok && (op5 == 5'b10110);

  logic rwe, aluinb, alusub, br, jp;
  assign rwe    = is_add | is_addi | is_lw | is_jal | is_setx;
  assign aluinb = is_addi | is_lw | is_sw;
  assign alusub = is_bne | is_blt | is_bex;
  assign br     = is_bne | is_blt;
  assign jp     = is_j | is_jal;

  logic [13:0]        dec_word;
  logic [ALUOP_W-1:0] dec_fop;
  logic               dec_md;

  assign dec_word = {rwe, is_sw, aluinb, alusub, is_sw, is_lw, br, jp,
                     is_bne, is_blt, is_jal, is_jr, is_setx, is_bex};

  always_comb begin
    dec_fop = ALUOP_W'(opcode_i);
    if (alusub)       dec_fop = ALUOP_W'(1);
    else if (is_addi) dec_fop = '0;
    else if (is_add)  dec_fop = alu_op_i;
  end

  assign dec_md = is_add && ((alu_op_i == ALUOP_W'(5'b00110)) ||
                             (alu_op_i == ALUOP_W'(5'b00111)));

  // ---------------------------------------------------------------- state
  state_t             state_q;
  logic               out_valid_q;
  logic [13:0]        ctrl_word_q;
  logic [ALUOP_W-1:0] final_opcode_q;
  logic               out_md_exc_q;
  logic               md_start_q;
  logic               md_is_div_q;
  logic [13:0]        pend_word_q;
  logic [ALUOP_W-1:0] pend_fop_q;
  logic               done_q;
  logic               exc_q;
`ifdef CTRL_MD_WATCHDOG_EN
  localparam int CNT_W = $clog2(MD_MAX_CYC + 1);
  logic [CNT_W-1:0]   cnt_q;
  logic               md_timeout_q;
`endif

  logic slot_free;
  logic accept;

  assign slot_free = !out_valid_q || out_ready_i;
  // Gated by reset so every output reads 0 while reset is held.
  assign in_ready_o = rst_ni && (state_q == IDLE) && slot_free;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      ctrl_word_q    <= '0;
      final_opcode_q <= '0;
      out_md_exc_q   <= 1'b0;
      md_start_q     <= 1'b0;
      md_is_div_q    <= 1'b0;
      pend_word_q    <= '0;
      pend_fop_q     <= '0;
      done_q         <= 1'b0;
      exc_q          <= 1'b0;
`ifdef CTRL_MD_WATCHDOG_EN
      cnt_q          <= '0;
      md_timeout_q   <= 1'b0;
`endif
    end else begin
      md_start_q  <= 1'b0;
      md_is_div_q <= 1'b0;
      if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept && dec_md) begin
            // Park the decoded word until the multdiv unit finishes.
            md_start_q  <= 1'b1;
            md_is_div_q <= alu_op_i[0];
            pend_word_q <= dec_word;
            pend_fop_q  <= dec_fop;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            state_q     <= MD_WAIT;
`ifdef CTRL_MD_WATCHDOG_EN
            cnt_q       <= '0;
`endif
          end else if (accept) begin
            out_valid_q    <= 1'b1;
            ctrl_word_q    <= dec_word;
            final_opcode_q <= dec_fop;
            out_md_exc_q   <= 1'b0;
`ifdef CTRL_MD_WATCHDOG_EN
            md_timeout_q   <= 1'b0;
`endif
          end
        end

        MD_WAIT: begin
          if (done_q && slot_free) begin
            out_valid_q    <= 1'b1;
            ctrl_word_q    <= pend_word_q;
            final_opcode_q <= pend_fop_q;
            out_md_exc_q   <= exc_q;
            state_q        <= IDLE;
`ifdef CTRL_MD_WATCHDOG_EN
            md_timeout_q   <= 1'b0;
`endif
          end
`ifdef CTRL_MD_WATCHDOG_EN
          else if (!done_q && slot_free && (cnt_q == CNT_W'(MD_MAX_CYC - 1))) begin
            // Give up on the unit: deliver without a register write.
            out_valid_q    <= 1'b1;
            ctrl_word_q    <= {1'b0, pend_word_q[12:0]};
            final_opcode_q <= pend_fop_q;
            out_md_exc_q   <= 1'b0;
            md_timeout_q   <= 1'b1;
            state_q        <= IDLE;
          end
`endif
          else begin
            // First md_done wins; its exception flag is captured with it.
            if (md_done_i && !done_q) begin
              done_q <= 1'b1;
              exc_q  <= md_exc_i;
            end
`ifdef CTRL_MD_WATCHDOG_EN
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
`endif
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o    = out_valid_q;
  assign ctrl_word_o    = ctrl_word_q;
  assign final_opcode_o = final_opcode_q;
  assign out_md_exc_o   = out_md_exc_q;
  assign md_start_o     = md_start_q;
  assign md_is_div_o    = md_is_div_q;
`ifdef CTRL_MD_WATCHDOG_EN
  assign md_timeout_o   = md_timeout_q;
`else
  assign md_timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// Bench for ctrl_decode_seq: directed stimulus, a transaction-level model
// checked every cycle at the falling edge, and literal spot checks.
module tb_ctrl_decode_seq;

  localparam int MAXC = 8;
`ifdef CTRL_MD_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       md_done = 1'b0;
  logic       md_exc = 1'b0;
  logic [4:0] opcode = '0;
  logic [4:0] alu_op = '0;

  logic        in_ready, out_valid, md_start, md_is_div, out_md_exc, md_timeout;
  logic [13:0] ctrl_word;
  logic [4:0]  final_opcode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ctrl_decode_seq #(.OPCODE_W(5), .ALUOP_W(5), .MD_MAX_CYC(MAXC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .alu_op_i(alu_op),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ctrl_word_o(ctrl_word), .final_opcode_o(final_opcode),
    .md_start_o(md_start), .md_is_div_o(md_is_div),
    .md_done_i(md_done), .md_exc_i(md_exc),
    .out_md_exc_o(out_md_exc), .md_timeout_o(md_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode table: {ctrl_word, final_opcode}, bits hand-assembled.
  function automatic logic [18:0] ref_decode(input logic [4:0] op, input logic [4:0] aop);
    case (op)
      5'd0:    return {14'h2000, aop};
      5'd1:    return {14'h0040, 5'd1};
      5'd2:    return {14'h04A0, 5'd1};
      5'd3:    return {14'h2048, 5'd3};
      5'd4:    return {14'h0004, 5'd4};
      5'd5:    return {14'h2800, 5'd0};
      5'd6:    return {14'h0490, 5'd1};
      5'd7:    return {14'h1A00, 5'd7};
      5'd8:    return {14'h2900, 5'd8};
      5'd21:   return {14'h2002, 5'd21};
      5'd22:   return {14'h0401, 5'd1};
      default: return {14'h0000, op};
    endcase
  endfunction

  // ---------------------------------------------------------------- model
  // Output slot contents, outstanding mult/div job, and issue pulse.
  logic        m_vld, m_mexc, m_mto, m_start, m_div;
  logic [13:0] m_word, m_pw;
  logic [4:0]  m_fop, m_pf;
  logic        m_busy, m_done, m_exc;
  int          m_wait;

  always @(negedge clk) begin
    logic        exp_rdy, acc, ismd;
    logic [18:0] d;
    if (!rst_n) begin
      m_vld = 0; m_mexc = 0; m_mto = 0; m_start = 0; m_div = 0;
      m_word = '0; m_fop = '0; m_pw = '0; m_pf = '0;
      m_busy = 0; m_done = 0; m_exc = 0; m_wait = 0;
    end else begin
      exp_rdy = !m_busy && (!m_vld || out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_vld);
      chk("md_start", md_start, m_start);
      chk("md_is_div", md_is_div, m_div);
      if (m_vld) begin
        chk("ctrl_word", ctrl_word, m_word);
        chk("final_opcode", final_opcode, m_fop);
        chk("out_md_exc", out_md_exc, m_mexc);
        chk("md_timeout", md_timeout, m_mto);
      end
      // Advance to the state after the coming rising edge.
      acc  = in_valid && exp_rdy;
      d    = ref_decode(opcode, alu_op);
      ismd = (opcode == 5'd0) && (alu_op == 5'd6 || alu_op == 5'd7);
      m_start = acc && ismd;
      m_div   = acc && ismd && (alu_op == 5'd7);
      if (m_vld && out_ready) m_vld = 0;
      if (acc && !ismd) begin
        m_vld = 1; m_word = d[18:5]; m_fop = d[4:0]; m_mexc = 0; m_mto = 0;
      end else if (acc) begin
        m_busy = 1; m_pw = d[18:5]; m_pf = d[4:0]; m_done = 0; m_exc = 0; m_wait = 0;
      end else if (m_busy) begin
        if (m_done && !m_vld) begin
          m_vld = 1; m_word = m_pw; m_fop = m_pf; m_mexc = m_exc; m_mto = 0; m_busy = 0;
        end else if (WD && !m_done && !m_vld && m_wait == MAXC - 1) begin
          m_vld = 1; m_word = m_pw & 14'h1FFF; m_fop = m_pf; m_mexc = 0; m_mto = 1; m_busy = 0;
        end else begin
          if (md_done && !m_done) begin m_done = 1; m_exc = md_exc; end
          m_wait++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [4:0] op, input logic [4:0] aop);
    in_valid = 1; opcode = op; alu_op = aop;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick(); in_valid = 0;
        $display("[TB] sent op=%0d alu_op=%0d", op, aop);
        return;
      end
      tick();
    end
    n_tests++; n_fail++;
    $display("[TB] FAIL send_timeout: op=%0d not accepted, in_ready=%0b", op, in_ready);
    in_valid = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctrl_word", ctrl_word, 0);
    chk("rst_md_start", md_start, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // addi, bne, unknown opcode
    out_ready = 1;
    send(5'd5, 5'd0);
    chk("addi_valid", out_valid, 1);
    chk("addi_word", ctrl_word, 14'h2800);
    chk("addi_fop", final_opcode, 5'd0);
    send(5'd2, 5'd0);
    chk("bne_word", ctrl_word, 14'h04A0);
    chk("bne_fop", final_opcode, 5'd1);
    send(5'd31, 5'd3);
    chk("unk_word", ctrl_word, 14'h0000);
    chk("unk_fop", final_opcode, 5'd31);
    tick();

    // Back-to-back stream, then a two-cycle stall
    in_valid = 1; opcode = 5'd0; alu_op = 5'd3; tick(); #1;
    chk("stream_add", ctrl_word, 14'h2000);
    chk("stream_add_fop", final_opcode, 5'd3);
    opcode = 5'd8; tick(); #1;
    chk("stream_lw", ctrl_word, 14'h2900);
    opcode = 5'd7; tick(); #1;
    chk("stream_sw", ctrl_word, 14'h1A00);
    opcode = 5'd3; out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("stall_word", ctrl_word, 14'h1A00);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1; tick(); #1;
    chk("after_stall_jal", ctrl_word, 14'h2048);
    in_valid = 0; tick();

    // mul, md_done 16 cycles after the issue pulse with md_exc=1
    send(5'd0, 5'd6); #1;
    chk("mul_start", md_start, 1);
    chk("mul_is_div", md_is_div, 0);
    chk("mul_in_ready", in_ready, 0);
    repeat (16) tick();
    md_done = 1; md_exc = 1; tick();
    md_done = 0; md_exc = 0; tick(); #1;
    chk("mul_valid", out_valid, 1);
    chk("mul_exc", out_md_exc, 1);
    chk("mul_word", ctrl_word, 14'h2000);
    chk("mul_fop", final_opcode, 5'd6);
    md_done = 1; tick(); md_done = 0;   // stray md_done in IDLE
    tick();

    // div with out_ready low at completion; prior word drains at issue
    send(5'd5, 5'd0);
    send(5'd0, 5'd7); #1;
    chk("div_start", md_start, 1);
    chk("div_is_div", md_is_div, 1);
    out_ready = 0;
    repeat (3) tick();
    md_done = 1; tick(); md_done = 0;
    repeat (4) tick(); #1;
    chk("div_held_valid", out_valid, 1);
    chk("div_held_word", ctrl_word, 14'h2000);
    chk("div_held_fop", final_opcode, 5'd7);
    out_ready = 1; tick(); #1;
    chk("div_drained", out_valid, 0);

    // md_done in the same cycle as the issue pulse
    send(5'd0, 5'd6);
    md_done = 1; tick(); md_done = 0; tick(); #1;
    chk("fast_done_valid", out_valid, 1);
    tick();

`ifdef CTRL_MD_WATCHDOG_EN
    // Watchdog: div with no md_done
    send(5'd0, 5'd7);
    repeat (7) tick(); #1;
    chk("wd_not_yet", out_valid, 0);
    tick(); #1;
    chk("wd_valid", out_valid, 1);
    chk("wd_timeout", md_timeout, 1);
    chk("wd_word", ctrl_word, 14'h0000);
    chk("wd_exc", out_md_exc, 0);
    md_done = 1; md_exc = 1; tick(); md_done = 0; md_exc = 0;
    tick();
`endif

    // Asynchronous reset during MD_WAIT, while md_start is high
    send(5'd0, 5'd6); #1;
    rst_n = 0; #1;
    chk("arst_md_start", md_start, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_word", ctrl_word, 0);
    chk("arst_fop", final_opcode, 0);
    chk("arst_exc", out_md_exc, 0);
    chk("arst_timeout", md_timeout, 0);
    tick(); rst_n = 1;
    tick(); #1;
    chk("arst_rel_in_ready", in_ready, 1);
    chk("arst_rel_md_start", md_start, 0);
    send(5'd8, 5'd0);
    chk("arst_lw_word", ctrl_word, 14'h2900);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
